// File: rtl/mult_if.sv
// Handshake and result bus between the EX-stage issue logic and the iterative multiplier.
// The master drives requests; the slave (mult_unit) returns status and the HI/LO registers.
interface mult_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [6:0]       opt;
  logic [WIDTH-1:0] opr1;
  logic [WIDTH-1:0] opr2;
  logic             flush;
  logic             busy;
  logic             done;
  logic             illegal_opt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, opt, opr1, opr2, flush,
    input  busy, done, illegal_opt, hi, lo
  );

  modport slave (
    input  start, opt, opr1, opr2, flush,
    output busy, done, illegal_opt, hi, lo
  );
endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add 32x32 multiplier owning the HI/LO registers; signed MULT always,
// unsigned MULTU only when MULT_UNSIGNED_EN is defined.
module mult_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [6:0]  OPT_MULT  = 7'h18,
  parameter logic [6:0]  OPT_MULTU = 7'h19
) (
  input logic   clk,
  input logic   rst,
  mult_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 sign_q, sign_d;
  logic                 done_q, done_d;

  logic                 idle, is_mult, is_multu, accept, use_raw;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [2*WIDTH-1:0]   prod;

  assign idle     = (state_q == StIdle);
  assign is_mult  = (bus.opt == OPT_MULT);
  assign is_multu = (bus.opt == OPT_MULTU);

`ifdef MULT_UNSIGNED_EN
  assign accept  = is_mult | is_multu;
  assign use_raw = is_multu;
`else
  // MULTU is explicitly rejected when unsigned support is compiled out
  assign accept  = is_mult & ~is_multu;
  assign use_raw = 1'b0;
`endif

  // Magnitude; the most negative value maps onto itself, which is correct as unsigned
  assign abs1 = bus.opr1[WIDTH-1] ? -bus.opr1 : bus.opr1;
  assign abs2 = bus.opr2[WIDTH-1] ? -bus.opr2 : bus.opr2;
  assign prod = sign_q ? -acc_q : acc_q;

  assign bus.busy        = ~idle;
  assign bus.done        = done_q;
  assign bus.illegal_opt = idle & bus.start & ~accept;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush && accept) begin
          mcand_d  = {{WIDTH{1'b0}}, (use_raw ? bus.opr1 : abs1)};
          mplier_d = use_raw ? bus.opr2 : abs2;
          sign_d   = use_raw ? 1'b0 : (bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!bus.flush) begin
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit: signed product table plus hand-written
// flush, reset, illegal-opt and busy-start sequences.
module tb_mult_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  mult_if #(.WIDTH(32)) bus ();

  mult_unit #(
    .WIDTH    (32),
    .OPT_MULT (7'h18),
    .OPT_MULTU(7'h19)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to done; checks latency and busy profile
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op,
                         input string nm);
    int e;
    bit seen;
    bit busy_ok;
    bus.start = 1'b1;
    bus.opt   = op;
    bus.opr1  = a;
    bus.opr2  = b;
    tick();
    bus.start = 1'b0;
    e       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && e <= 40) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.busy) busy_ok = 1'b0;
        tick();
        e++;
      end
    end
    check({nm, " latency"}, 64'(e), 64'd33);
    check({nm, " busy_during"}, {63'd0, busy_ok}, 64'd1);
    check({nm, " busy_at_done"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    bit          any_done;
    bit          bad_illegal;

    n_checks = 0;
    n_err    = 0;
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F};
    vecs[1] = '{32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[4] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
    vecs[7] = '{32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.opt   = 7'h00;
    bus.opr1  = '0;
    bus.opr2  = '0;
    bus.flush = 1'b0;
    tick();
    tick();
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    tick();

    // Table loop; each next request is issued in the previous done cycle (back-to-back)
    for (int i = 0; i < 9; i++) begin
      do_mult(vecs[i].a, vecs[i].b, 7'h18, $sformatf("vec%0d", i));
      check($sformatf("vec%0d hilo", i), {bus.hi, bus.lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end
    tick();
    check("done one-cycle", {63'd0, bus.done}, 64'd0);

    // Start pulses while busy are ignored and never flag illegal_opt
    bus.start = 1'b1;
    bus.opt   = 7'h18;
    bus.opr1  = 32'd7;
    bus.opr2  = 32'd7;
    tick();
    bad_illegal = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.opt  = (k % 2 == 0) ? 7'h21 : 7'h18;
      bus.opr1 = 32'd100;
      bus.opr2 = 32'd100;
      #1;
      if (bus.illegal_opt) bad_illegal = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    check("busy start no illegal", {63'd0, bad_illegal}, 64'd0);
    any_done = 1'b0;
    for (int k = 0; k < 40 && !any_done; k++) begin
      if (bus.done) any_done = 1'b1;
      else tick();
    end
    check("7x7 done", {63'd0, any_done}, 64'd1);
    check("7x7 hilo", {bus.hi, bus.lo}, 64'd49);
    tick();
    tick();
    check("no queued op", {63'd0, bus.busy}, 64'd0);

    // Flush mid-CALC together with a fresh start
    do_mult(32'd2, 32'd3, 7'h18, "pre-flush");
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    check("pre-flush hilo", {hold_hi, hold_lo}, 64'd6);
    bus.start = 1'b1;
    bus.opt   = 7'h18;
    bus.opr1  = 32'd7;
    bus.opr2  = 32'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    bus.flush = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush busy", {63'd0, bus.busy}, 64'd0);
    any_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) any_done = 1'b1;
      tick();
    end
    check("flush no done", {63'd0, any_done}, 64'd0);
    check("flush hilo kept", {bus.hi, bus.lo}, {hold_hi, hold_lo});

    // Flush beats start in IDLE
    bus.flush = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("idle flush wins", {63'd0, bus.busy}, 64'd0);

    // Unsupported opt: combinational flag for that cycle only
    bus.start = 1'b1;
    bus.opt   = 7'h21;
    #1;
    check("illegal 21 flag", {63'd0, bus.illegal_opt}, 64'd1);
    tick();
    bus.start = 1'b0;
    #1;
    check("illegal clears", {63'd0, bus.illegal_opt}, 64'd0);
    check("illegal no busy", {63'd0, bus.busy}, 64'd0);
    check("illegal hilo kept", {bus.hi, bus.lo}, {hold_hi, hold_lo});
    tick();

`ifdef MULT_UNSIGNED_EN
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'h19, "multu");
    check("multu hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
`else
    bus.start = 1'b1;
    bus.opt   = 7'h19;
    bus.opr1  = 32'hFFFF_FFFF;
    bus.opr2  = 32'hFFFF_FFFF;
    #1;
    check("multu illegal", {63'd0, bus.illegal_opt}, 64'd1);
    tick();
    bus.start = 1'b0;
    check("multu no busy", {63'd0, bus.busy}, 64'd0);
    tick();
`endif

    // Asynchronous reset in the middle of CALC
    do_mult(32'h0001_0000, 32'h0001_0000, 7'h18, "pre-reset");
    check("pre-reset hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
    bus.start = 1'b1;
    bus.opt   = 7'h18;
    bus.opr1  = 32'd9;
    bus.opr2  = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst busy", {63'd0, bus.busy}, 64'd0);
    check("async rst hilo", {bus.hi, bus.lo}, 64'd0);
    tick();
    rst = 1'b0;
    any_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) any_done = 1'b1;
      tick();
    end
    check("rst no done", {63'd0, any_done}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
